// File: rtl/sr_ff_driver.sv
// sr_ff_driver: drives s/r excitation so an external SR flop reaches each target bit, with readback retry and stats
module sr_ff_driver #(
  parameter int PULSE_CYC  = 1,
  parameter int SETTLE_CYC = 1,
  parameter int MAX_RETRY  = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  input  logic             q_fb,
  input  logic             err_clr,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             done,
  output logic             ok,
  output logic             err,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam logic [1:0] IDLE = 2'd0, DRIVE = 2'd1, SETTLE = 2'd2, CHECK = 2'd3;
  logic [1:0]  state;
  logic [15:0] cnt;
  logic [7:0]  retry;
  logic        tgt_q;
  assign tgt_ready = state == IDLE;
  assign busy      = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      retry     <= '0;
      tgt_q     <= 1'b0;
      s         <= 1'b0;
      r         <= 1'b0;
      done      <= 1'b0;
      ok        <= 1'b0;
      err       <= 1'b0;
      match_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      done <= 1'b0;
      ok   <= 1'b0;
      if (err_clr) err <= 1'b0;
      case (state)
        IDLE: if (tgt_valid) begin
          tgt_q <= tgt_bit;
          retry <= '0;
          if (tgt_bit != q_fb) begin
            state <= DRIVE;
            s     <= tgt_bit;
            r     <= ~tgt_bit;
            cnt   <= 16'(PULSE_CYC - 1);
          end else begin
            state <= SETTLE;
            cnt   <= 16'(SETTLE_CYC - 1);
          end
        end
        DRIVE: if (cnt == '0) begin
          s     <= 1'b0;
          r     <= 1'b0;
          state <= SETTLE;
          cnt   <= 16'(SETTLE_CYC - 1);
        end else cnt <= cnt - 16'd1;
        SETTLE: if (cnt == '0) state <= CHECK; else cnt <= cnt - 16'd1;
        CHECK: if (q_fb == tgt_q) begin
          match_cnt <= match_cnt + CNT_W'(~&match_cnt);
          done      <= 1'b1;
          ok        <= 1'b1;
          state     <= IDLE;
        end else if (retry < 8'(MAX_RETRY)) begin
          // a mismatch means q_fb is the opposite of tgt_q, so the excitation always pulses
          retry <= retry + 8'd1;
          s     <= tgt_q;
          r     <= ~tgt_q;
          cnt   <= 16'(PULSE_CYC - 1);
          state <= DRIVE;
        end else begin
          err     <= 1'b1;
          err_cnt <= err_cnt + CNT_W'(~&err_cnt);
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
